// File: rtl/prim_arb_skid.sv
// rtl/prim_arb_skid.sv - two-entry registered skid buffer between an arbiter and its consumer
module prim_arb_skid #(
  parameter int DW   = 32,
  parameter int IdxW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [DW-1:0]   data_i,
  input  logic [IdxW-1:0] idx_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [DW-1:0]   data_o,
  output logic [IdxW-1:0] idx_o,
  output logic [1:0]      count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            valid_q, ready_q;
  logic [DW-1:0]   head_data_q, skid_data_q;
  logic [IdxW-1:0] head_idx_q, skid_idx_q;
  logic            push, pop;
  logic            load_head_in, load_head_skid, load_skid;

  // Handshakes use only registered ready/valid, so no input reaches an output.
  assign push = valid_i & ready_q;
  assign pop  = valid_q & ready_i;

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = head_data_q;
  assign idx_o   = head_idx_q;
  assign count_o = state_q;

  // Next occupancy and which storage register captures what; flush suppresses every load.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            load_head_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_head_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, registered handshake outputs and payload storage; reset beats flush and traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      head_data_q <= '0;
      head_idx_q  <= '0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      if (load_head_in) begin
        head_data_q <= data_i;
        head_idx_q  <= idx_i;
      end else if (load_head_skid) begin
        head_data_q <= skid_data_q;
        head_idx_q  <= skid_idx_q;
      end
      if (load_skid) begin
        skid_data_q <= data_i;
        skid_idx_q  <= idx_i;
      end
    end
  end

endmodule

// File: tb/tb_prim_arb_skid.sv
// tb/tb_prim_arb_skid.sv - self-checking bench for prim_arb_skid against a queue model
module tb_prim_arb_skid;

  localparam int DW   = 32;
  localparam int IdxW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, valid_i, ready_i;
  logic            ready_o, valid_o;
  logic [DW-1:0]   data_i, data_o;
  logic [IdxW-1:0] idx_i, idx_o;
  logic [1:0]      count_o;

  int checks = 0;
  int errors = 0;

  // Reference: ordered list of live beats, {idx, data}
  logic [IdxW+DW-1:0] q[$];
  logic               last_push;

  prim_arb_skid #(.DW(DW), .IdxW(IdxW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .idx_i   (idx_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply the model's view of the coming edge, then step one clock and settle.
  task automatic advance();
    bit pop, push;
    pop  = 1'b0;
    push = 1'b0;
    if (rst_i || flush_i) begin
      q.delete();
    end else begin
      pop  = (q.size() != 0) && ready_i;
      push = valid_i && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({idx_i, data_i});
    end
    last_push = push;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; idx_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    advance();
    advance();
    rst_i = 1'b0;
    checks++;
    if (count_o !== 2'd0 || valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0 || idx_o !== '0) begin
      errors++;
      $display("FAIL reset: count=%0d valid=%b ready=%b data=%h idx=%0d, want 0 0 1 0 0",
               count_o, valid_o, ready_o, data_o, idx_o);
    end
  endtask

  task automatic test_single();
    idle_inputs();
    valid_i = 1'b1; data_i = 32'hA5; idx_i = 3'd2; ready_i = 1'b1;
    advance();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hA5 || idx_o !== 3'd2 || count_o !== 2'd1) begin
      errors++;
      $display("FAIL single: valid=%b data=%h idx=%0d count=%0d, want 1 a5 2 1",
               valid_o, data_o, idx_o, count_o);
    end
    advance();
    checks++;
    if (count_o !== 2'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: count=%0d valid=%b, want 0 0", count_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    valid_i = 1'b1; data_i = 32'h11; idx_i = 3'd1;
    advance();
    data_i = 32'h22; idx_i = 3'd5;
    advance();
    // upstream keeps offering a third beat while full
    data_i = 32'h99; idx_i = 3'd7;
    advance();
    checks++;
    if (count_o !== 2'd2 || ready_o !== 1'b0 || data_o !== 32'h11 || idx_o !== 3'd1) begin
      errors++;
      $display("FAIL full_hold: count=%0d ready=%b data=%h idx=%0d, want 2 0 11 1",
               count_o, ready_o, data_o, idx_o);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    advance();
    checks++;
    if (data_o !== 32'h22 || idx_o !== 3'd5 || count_o !== 2'd1) begin
      errors++;
      $display("FAIL drain_second: data=%h idx=%0d count=%0d, want 22 5 1", data_o, idx_o, count_o);
    end
    advance();
    checks++;
    if (count_o !== 2'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d valid=%b, want 0 0", count_o, valid_o);
    end
  endtask

  task automatic test_stream();
    idle_inputs();
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; data_i = i; idx_i = i[IdxW-1:0];
      advance();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b1 || data_o !== i || idx_o !== i[IdxW-1:0]) begin
        errors++;
        $display("FAIL stream[%0d]: ready=%b valid=%b data=%h idx=%0d, want 1 1 %h %0d",
                 i, ready_o, valid_o, data_o, idx_o, i, i[IdxW-1:0]);
      end
    end
    valid_i = 1'b0;
    advance();
    checks++;
    if (count_o !== 2'd0) begin
      errors++;
      $display("FAIL stream_end: count=%0d, want 0", count_o);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    valid_i = 1'b1; data_i = 32'h44; idx_i = 3'd3;
    advance();
    data_i = 32'h55; idx_i = 3'd4;
    advance();
    flush_i = 1'b1; data_i = 32'h33; idx_i = 3'd6;
    advance();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (count_o !== 2'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, want 0 0 1", count_o, valid_o, ready_o);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (valid_o !== 1'b0 || data_o === 32'h33) begin
        errors++;
        $display("FAIL flush_discard[%0d]: valid=%b data=%h, want valid 0 and data not 33",
                 i, valid_o, data_o);
      end
    end
  endtask

  task automatic test_reset_full();
    idle_inputs();
    valid_i = 1'b1; data_i = 32'h66; idx_i = 3'd5;
    advance();
    data_i = 32'h77; idx_i = 3'd6;
    advance();
    checks++;
    if (count_o !== 2'd2) begin
      errors++;
      $display("FAIL prereset_full: count=%0d, want 2", count_o);
    end
    rst_i = 1'b1; ready_i = 1'b1;
    advance();
    rst_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (count_o !== 2'd0 || valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0 || idx_o !== '0) begin
      errors++;
      $display("FAIL reset_full: count=%0d valid=%b ready=%b data=%h idx=%0d, want 0 0 1 0 0",
               count_o, valid_o, ready_o, data_o, idx_o);
    end
  endtask

  task automatic test_random();
    logic            prev_stall;
    logic [DW-1:0]   prev_data;
    logic [IdxW-1:0] prev_idx;
    int              popped;
    idle_inputs();
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_idx   = '0;
    popped     = 0;
    for (int c = 0; c < 600; c++) begin
      // upstream: hold an offered beat until it is accepted (or flushed)
      if (!valid_i || last_push) begin
        valid_i = ($urandom_range(0, 99) < 60);
        data_i  = $urandom;
        idx_i   = $urandom_range(0, 7);
      end
      ready_i = ($urandom_range(0, 99) < 55);
      flush_i = ($urandom_range(0, 63) == 0);
      if (q.size() != 0 && ready_i && !flush_i) popped++;
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_idx   = idx_o;
      advance();
      if (flush_i) valid_i = 1'b0;
      flush_i = 1'b0;
      checks++;
      if (count_o !== q.size() || valid_o !== (q.size() != 0) || ready_o !== (q.size() != 2)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: count=%0d valid=%b ready=%b, want count %0d", c,
                 count_o, valid_o, ready_o, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if ({idx_o, data_o} !== q[0]) begin
          errors++;
          $display("FAIL rand_head[%0d]: idx=%0d data=%h, want %h", c, idx_o, data_o, q[0]);
        end
      end
      if (prev_stall && valid_o) begin
        checks++;
        if (data_o !== prev_data || idx_o !== prev_idx) begin
          errors++;
          $display("FAIL rand_hold[%0d]: data=%h idx=%0d, want %h %0d", c, data_o, idx_o,
                   prev_data, prev_idx);
        end
      end
    end
    checks++;
    if (popped < 50) begin
      errors++;
      $display("FAIL rand_activity: popped=%0d, want at least 50", popped);
    end
  endtask

  initial begin
    last_push = 1'b0;
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
